// File: rtl/ysyx_23060136_exu_div_ctrl.sv
// ysyx_23060136_exu_div_ctrl
//   Sequencing controller between the EXU issue stage and the shared
//   iterative divider. It decodes DIV/DIVU/REM/REMU (and W forms), prepares
//   operands, resolves divide-by-zero and signed overflow locally, and holds
//   the selected, sign-extended result under an out_valid/out_ready handshake.
//
//   Optional feature: define YSYX_23060136_DIV_RESULT_CACHE_EN to add a
//   one-entry result cache. With it, a repeat of the last divider-produced
//   operation (for example DIV followed by REM on the same operands)
//   completes without using the divider.
//
// Handshakes (all sampled on the rising edge of clk):
//   in_valid/in_ready   : a request transfers when in_valid & in_ready & ~flush.
//                         in_ready is high only in IDLE.
//   div_valid/div_ready : request to the divider transfers when both are high;
//                         div_valid, dividend, divisor, div_signed and divw
//                         stay stable until then.
//   div_out_valid       : one-cycle result pulse from the divider, with no
//                         back-pressure.
//   out_valid/out_ready : the result transfers when both are high.
//                         out_result stays stable while out_valid is high.
//                         flush in DONE drops the result instead.
//
// dbg_state exposes the FSM state for checkers.
module ysyx_23060136_exu_div_ctrl #(
    parameter int XLEN = 64,
    parameter int HALF = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            div_valid,
    input  logic            div_ready,
    output logic            div_signed,
    output logic            divw,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] quotient,
    input  logic [XLEN-1:0] remainder,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Most-negative values for the signed-overflow check.
    localparam logic [XLEN-1:0] MIN_NEG_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_NEG_W = {{(XLEN-HALF+1){1'b1}}, {(HALF-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
        return {{(XLEN-HALF){v[HALF-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_half(input logic [HALF-1:0] v);
        return {{(XLEN-HALF){1'b0}}, v};
    endfunction

    state_t state_q, state_d;
    logic            rem_q, rem_d;          // 1: REM/REMU select remainder
    logic            divw_q, divw_d;
    logic            div_signed_q, div_signed_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] out_result_q, out_result_d;

    logic            accept;
    logic            prep_signed;
    logic [XLEN-1:0] prep_src1;
    logic [XLEN-1:0] prep_src2;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic            cache_hit;
    logic [XLEN-1:0] cache_q_val;
    logic [XLEN-1:0] cache_r_val;
    logic [XLEN-1:0] fast_q;
    logic [XLEN-1:0] fast_r;
    logic [XLEN-1:0] fast_sel;
    logic [XLEN-1:0] fast_result;
    logic [XLEN-1:0] div_sel;
    logic [XLEN-1:0] div_result;

    assign in_ready   = (state_q == S_IDLE) & ~rst;
    assign out_valid  = (state_q == S_DONE);
    assign div_valid  = (state_q == S_ISSUE);
    assign div_signed = div_signed_q;
    assign divw       = divw_q;
    assign dividend   = dividend_q;
    assign divisor    = divisor_q;
    assign out_result = out_result_q;
    assign dbg_state  = state_q;

    assign accept = in_valid & in_ready & ~flush;

    // Operand preparation: W forms take the low half, sign- or zero-extended.
    always_comb begin
        prep_signed = ~in_op[0];
        prep_src1   = in_src1;
        prep_src2   = in_src2;
        if (in_word) begin
            if (prep_signed) begin
                prep_src1 = sext_half(in_src1[HALF-1:0]);
                prep_src2 = sext_half(in_src2[HALF-1:0]);
            end else begin
                prep_src1 = zext_half(in_src1[HALF-1:0]);
                prep_src2 = zext_half(in_src2[HALF-1:0]);
            end
        end
    end

    // Special cases resolved locally; they take priority over a cache hit.
    always_comb begin
        div_zero = (prep_src2 == '0);
        overflow = prep_signed & (prep_src2 == '1) &
                   (prep_src1 == (in_word ? MIN_NEG_W : MIN_NEG_D));
        special  = div_zero | overflow;
        fast_q   = cache_q_val;
        fast_r   = cache_r_val;
        if (div_zero) begin
            fast_q = '1;
            fast_r = prep_src1;
        end else if (overflow) begin
            fast_q = prep_src1;
            fast_r = '0;
        end
        fast_sel    = in_op[1] ? fast_r : fast_q;
        fast_result = in_word ? sext_half(fast_sel[HALF-1:0]) : fast_sel;
    end

    // Result selection for a divider-produced value. W forms always
    // sign-extend bit HALF-1, including DIVUW/REMUW.
    always_comb begin
        div_sel    = rem_q ? remainder : quotient;
        div_result = divw_q ? sext_half(div_sel[HALF-1:0]) : div_sel;
    end

`ifdef YSYX_23060136_DIV_RESULT_CACHE_EN
    logic            cache_valid_q, cache_valid_d;
    logic [XLEN-1:0] cache_src1_q, cache_src1_d;
    logic [XLEN-1:0] cache_src2_q, cache_src2_d;
    logic            cache_signed_q, cache_signed_d;
    logic            cache_word_q, cache_word_d;
    logic [XLEN-1:0] cache_quo_q, cache_quo_d;
    logic [XLEN-1:0] cache_rem_q, cache_rem_d;

    // A hit requires all four key fields to match the prepared request.
    always_comb begin
        cache_hit   = cache_valid_q &
                      (cache_src1_q == prep_src1) &
                      (cache_src2_q == prep_src2) &
                      (cache_signed_q == prep_signed) &
                      (cache_word_q == in_word);
        cache_q_val = cache_quo_q;
        cache_r_val = cache_rem_q;
    end

    // Refill only when a divider result reaches DONE; flushed or drained
    // results never enter the cache.
    always_comb begin
        cache_valid_d  = cache_valid_q;
        cache_src1_d   = cache_src1_q;
        cache_src2_d   = cache_src2_q;
        cache_signed_d = cache_signed_q;
        cache_word_d   = cache_word_q;
        cache_quo_d    = cache_quo_q;
        cache_rem_d    = cache_rem_q;
        if ((state_q == S_WAIT) && div_out_valid && !flush) begin
            cache_valid_d  = 1'b1;
            cache_src1_d   = dividend_q;
            cache_src2_d   = divisor_q;
            cache_signed_d = div_signed_q;
            cache_word_d   = divw_q;
            cache_quo_d    = quotient;
            cache_rem_d    = remainder;
        end
    end

    // Cache storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid_q  <= 1'b0;
            cache_src1_q   <= '0;
            cache_src2_q   <= '0;
            cache_signed_q <= 1'b0;
            cache_word_q   <= 1'b0;
            cache_quo_q    <= '0;
            cache_rem_q    <= '0;
        end else begin
            cache_valid_q  <= cache_valid_d;
            cache_src1_q   <= cache_src1_d;
            cache_src2_q   <= cache_src2_d;
            cache_signed_q <= cache_signed_d;
            cache_word_q   <= cache_word_d;
            cache_quo_q    <= cache_quo_d;
            cache_rem_q    <= cache_rem_d;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_q_val = '0;
    assign cache_r_val = '0;
`endif

    // Next-state and datapath register updates for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        divw_d       = divw_q;
        div_signed_d = div_signed_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        out_result_d = out_result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_d        = in_op[1];
                    divw_d       = in_word;
                    div_signed_d = prep_signed;
                    dividend_d   = prep_src1;
                    divisor_d    = prep_src2;
                    if (special || cache_hit) begin
                        out_result_d = fast_result;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // A request that the divider took must still be drained.
                if (flush) begin
                    state_d = div_ready ? S_DRAIN : S_IDLE;
                end else if (div_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = div_out_valid ? S_IDLE : S_DRAIN;
                end else if (div_out_valid) begin
                    out_result_d = div_result;
                    state_d      = S_DONE;
                end
            end
            S_DRAIN: begin
                // The divider cannot be killed; swallow its result.
                if (div_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rem_q        <= 1'b0;
            divw_q       <= 1'b0;
            div_signed_q <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            divw_q       <= divw_d;
            div_signed_q <= div_signed_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            out_result_q <= out_result_d;
        end
    end

    // A divider result is only legal while a divide is outstanding.
    ap_no_stray_div_result: assert property (
        @(posedge clk) disable iff (rst)
        div_out_valid |-> ((state_q == S_WAIT) || (state_q == S_DRAIN))
    );

endmodule

// File: tb/tb_ysyx_23060136_exu_div_ctrl.sv
// Directed testbench for ysyx_23060136_exu_div_ctrl. The divider side is
// played by the bench: it raises div_ready and pulses div_out_valid with
// hand-computed quotient/remainder values.
module tb_ysyx_23060136_exu_div_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_word;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic        divw;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    ysyx_23060136_exu_div_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_word       (in_word),
        .in_src1       (in_src1),
        .in_src2       (in_src2),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .div_valid     (div_valid),
        .div_ready     (div_ready),
        .div_signed    (div_signed),
        .divw          (divw),
        .dividend      (dividend),
        .divisor       (divisor),
        .div_out_valid (div_out_valid),
        .quotient      (quotient),
        .remainder     (remainder),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one request starting at a negedge; returns at the negedge after
    // the accepting rising edge.
    task automatic send_req(input logic [1:0] op, input logic w,
                            input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_word  = w;
        in_src1  = a;
        in_src2  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Request that goes through the divider and ends in DONE.
    task automatic to_done_via_div(input string tag, input logic [1:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] q, input logic [63:0] r,
                                   input logic [63:0] exp_dvd, input logic [63:0] exp_dvs,
                                   input logic exp_sgn, input logic exp_w,
                                   input logic [63:0] exp_res);
        exp_q.push_back(exp_res);
        send_req(op, w, a, b);
        check({tag, "_div_valid"}, {63'd0, div_valid}, 64'd1);
        check({tag, "_dividend"}, dividend, exp_dvd);
        check({tag, "_divisor"}, divisor, exp_dvs);
        check({tag, "_signed_w"}, {62'd0, div_signed, divw}, {62'd0, exp_sgn, exp_w});
        check({tag, "_in_ready_busy"}, {63'd0, in_ready}, 64'd0);
        // One stall cycle: request must be held.
        @(negedge clk);
        check({tag, "_issue_hold"}, {63'd0, div_valid}, 64'd1);
        div_ready = 1'b1;
        @(negedge clk);
        div_ready = 1'b0;
        check({tag, "_div_valid_drop"}, {63'd0, div_valid}, 64'd0);
        repeat (2) @(negedge clk);
        div_out_valid = 1'b1;
        quotient      = q;
        remainder     = r;
        @(negedge clk);
        div_out_valid = 1'b0;
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_out_result"}, out_result, exp_q.pop_front());
    endtask

    // Request resolved without the divider: out_valid one cycle after accept.
    task automatic to_done_fast(input string tag, input logic [1:0] op, input logic w,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] exp_res);
        exp_q.push_back(exp_res);
        send_req(op, w, a, b);
        check({tag, "_no_div_valid"}, {63'd0, div_valid}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_out_result"}, out_result, exp_q.pop_front());
    endtask

    task automatic finish_done(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] held;
        int bad;
        rst = 1'b1;
        in_valid = 1'b0; in_op = 2'd0; in_word = 1'b0;
        in_src1 = '0; in_src2 = '0; flush = 1'b0; out_ready = 1'b0;
        div_ready = 1'b0; div_out_valid = 1'b0; quotient = '0; remainder = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_valids", {62'd0, out_valid, div_valid}, 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_operands", dividend | divisor, 64'd0);
        check("rst_ctrl", {62'd0, div_signed, divw}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // DIV -7 / 2 -> Q=-3.
        to_done_via_div("div_neg", OP_DIV, 1'b0, -64'sd7, 64'd2, -64'sd3, -64'sd1,
                        64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
        finish_done("div_neg");

        // REMUW: low word zero-extended to the divider, R=9.
        to_done_via_div("remuw", OP_REMU, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'h10,
                        64'h0FFF_FFFF, 64'd9,
                        64'h0000_0000_FFFF_FFF9, 64'h10, 1'b0, 1'b1, 64'd9);
        finish_done("remuw");

        // DIVUW quotient with bit 31 set is sign-extended.
        to_done_via_div("divuw_sext", OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1,
                        64'h0000_0000_FFFF_FFFE, 64'd0,
                        64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        finish_done("divuw_sext");

        // Special cases.
        to_done_fast("divw_ovf", OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        finish_done("divw_ovf");
        to_done_fast("divu_zero", OP_DIVU, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        finish_done("divu_zero");
        to_done_fast("rem_zero", OP_REM, 1'b0, 64'd5, 64'd0, 64'd5);
        finish_done("rem_zero");
        to_done_fast("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        finish_done("div_ovf");
        to_done_fast("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0);
        finish_done("rem_ovf");
        to_done_fast("remuw_zero", OP_REMU, 1'b1, 64'h0000_0000_8000_0005, 64'h1_0000_0000,
                     64'hFFFF_FFFF_8000_0005);
        finish_done("remuw_zero");

        // Flush during WAIT, result 10 cycles later is drained.
        send_req(OP_DIV, 1'b0, 64'd100, 64'd7);
        div_ready = 1'b1;
        @(negedge clk);
        div_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || div_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("drain_blocked", 64'(bad), 64'd0);
        in_valid = 1'b0;
        div_out_valid = 1'b1;
        quotient = 64'd14;
        remainder = 64'd2;
        @(negedge clk);
        div_out_valid = 1'b0;
        check("drain_to_idle", {62'd0, out_valid, in_ready}, 64'd1);

        // Flush in ISSUE without handshake.
        send_req(OP_DIV, 1'b0, 64'd200, 64'd9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("issue_flush", {62'd0, div_valid, in_ready}, 64'd1);

        // Flush together with div_ready in ISSUE -> drain.
        send_req(OP_DIV, 1'b0, 64'd300, 64'd11);
        flush = 1'b1;
        div_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        div_ready = 1'b0;
        check("issue_flush_hs", {62'd0, div_valid, in_ready}, 64'd0);
        div_out_valid = 1'b1;
        @(negedge clk);
        div_out_valid = 1'b0;
        check("issue_flush_hs_idle", {62'd0, out_valid, in_ready}, 64'd1);

        // Flush together with div_out_valid in WAIT -> result discarded.
        send_req(OP_DIV, 1'b0, 64'd400, 64'd13);
        div_ready = 1'b1;
        @(negedge clk);
        div_ready = 1'b0;
        flush = 1'b1;
        div_out_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        div_out_valid = 1'b0;
        check("wait_flush_pulse", {62'd0, out_valid, in_ready}, 64'd1);

        // Flush blocks acceptance in IDLE.
        flush = 1'b1;
        send_req(OP_DIV, 1'b0, 64'd500, 64'd3);
        flush = 1'b0;
        check("idle_flush_no_accept", {61'd0, div_valid, out_valid, in_ready}, 64'd1);

        // DONE held for 5 cycles with out_ready low.
        to_done_via_div("hold", OP_DIVU, 1'b0, 64'd50, 64'd5, 64'd10, 64'd0,
                        64'd50, 64'd5, 1'b0, 1'b0, 64'd10);
        held = out_result;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_result !== 64'd10 || out_result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        finish_done("hold");

        // Flush and out_ready together in DONE.
        to_done_via_div("flush_done", OP_DIVU, 1'b0, 64'd60, 64'd6, 64'd10, 64'd0,
                        64'd60, 64'd6, 1'b0, 1'b0, 64'd10);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        check("flush_done_idle", {62'd0, out_valid, in_ready}, 64'd1);

        // DIV then REM on the same operands.
        to_done_via_div("pair_div", OP_DIV, 1'b0, 64'd1000, 64'd7, 64'd142, 64'd6,
                        64'd1000, 64'd7, 1'b1, 1'b0, 64'd142);
        finish_done("pair_div");
`ifdef YSYX_23060136_DIV_RESULT_CACHE_EN
        to_done_fast("pair_rem_hit", OP_REM, 1'b0, 64'd1000, 64'd7, 64'd6);
        finish_done("pair_rem_hit");
`else
        to_done_via_div("pair_rem", OP_REM, 1'b0, 64'd1000, 64'd7, 64'd142, 64'd6,
                        64'd1000, 64'd7, 1'b1, 1'b0, 64'd6);
        finish_done("pair_rem");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060136_exu_div_ctrl.md
Name: ysyx_23060136_exu_div_ctrl

Overview:
- Sequencing controller between the EXU issue stage and the shared 64-bit iterative divider (valid/ready in, out_valid back).
- Decodes RV64M DIV/DIVU/REM/REMU and their W forms, and drives the divider's signed/word controls and operands.
- Resolves divide-by-zero and signed overflow without invoking the divider.
- Selects and sign-extends the result, holds it under an out_valid/out_ready handshake, and supports pipeline flush, including draining a divide already in flight.

Parameters:
- XLEN, 64, operand/result width.
- HALF, 32, word-op width (XLEN/2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EXU request valid
- in_ready  out  1  controller can accept a request
- in_op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- in_word  in  1  W-form op (DIVW etc.)
- in_src1  in  XLEN  dividend
- in_src2  in  XLEN  divisor
- flush  in  1  kill current op
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  final rd value
- div_valid  out  1  request to divider
- div_ready  in  1  divider accepts
- div_signed  out  1  signed divide
- divw  out  1  word divide
- dividend  out  XLEN  to divider
- divisor  out  XLEN  to divider
- div_out_valid  in  1  divider result valid (1-cycle pulse)
- quotient  in  XLEN  from divider
- remainder  in  XLEN  from divider

Behaviour:
- Clock is clk; reset is rst, synchronous active-high. Registers are updated on the rising edge.
- Reset values:
  - State = IDLE.
  - out_valid=0, div_valid=0, out_result=0, dividend=0, divisor=0, div_signed=0, divw=0.
  - in_ready=0 while rst is high, 1 on the first cycle after reset releases.
- in_ready is asserted only in IDLE. A request is accepted on in_valid & in_ready & ~flush, and the op, word flag and operands are latched.
- Operand prep:
  - Signed = ~in_op[0].
  - W ops: low HALF bits are sign-extended (signed) or zero-extended (unsigned).
  - Non-W ops: operands pass through unchanged.
- Special cases, evaluated on the prepared operands at accept:
  - Divisor==0: Q=all-ones, R=dividend.
  - Signed, dividend=most-negative (of the HALF width for W ops) and divisor=-1: Q=dividend, R=0.
  - Either case goes directly to DONE. out_valid rises the cycle after accept, i.e. latency 1.
- States:
  - IDLE:
    - accept & special -> DONE.
    - accept -> ISSUE.
  - ISSUE:
    - div_valid=1, with operands and controls held stable.
    - div_ready -> WAIT.
    - flush without a handshake -> IDLE.
    - flush & div_ready in the same cycle -> DRAIN.
  - WAIT:
    - div_out_valid -> capture the selection and go to DONE.
    - flush -> DRAIN.
    - flush & div_out_valid in the same cycle -> IDLE; the result is discarded.
  - DRAIN:
    - The divider has no kill, so the controller waits for div_out_valid, discards it, then -> IDLE.
    - in_ready=0 throughout.
  - DONE:
    - out_valid=1 and out_result stays stable until out_ready.
    - out_ready -> IDLE.
    - flush -> IDLE with no transfer; flush has priority over out_ready.
- Result:
  - REM/REMU select R, otherwise Q.
  - W ops: out_result = sign-extend(sel[HALF-1:0]). This applies to DIVUW/REMUW too, per the ISA.
- A div_out_valid arriving in IDLE, ISSUE or DONE is ignored. This is a protocol error; an assertion flags it in simulation.
- Only one op is in flight; the controller is not pipelined.
- Minimum normal latency: accept N, div_valid N+1, out_valid one cycle after the div_out_valid pulse.

Optional Feature:
- Macro: YSYX_23060136_DIV_RESULT_CACHE_EN.
- Defined:
  - A one-entry cache holds {prepared src1, src2, signed, word, Q, R} for the last divider-produced result that reached DONE.
  - Validity is cleared by reset. Drained or flushed results are never written.
  - On accept, a match on all four key fields goes to DONE with latency 1 and selects Q or R from the cache, so DIV followed by REM on the same operands costs one cycle.
  - Special cases still take priority.
- Undefined: no cache storage, and every non-special op goes through the divider.

Test Plan:
- DIV src1=-7, src2=2, divider returns Q=-3, R=-1 -> div_signed=1, divw=0, out_result=0xFFFFFFFFFFFFFFFD.
- REMUW src1=0x00000001_FFFFFFF9, src2=0x10 -> dividend=0x00000000FFFFFFF9, divw=1, div_signed=0; divider R=9 -> out_result=9.
- DIVW src1=0x80000000, src2=0xFFFFFFFF -> div_valid never asserts; out_valid the next cycle with out_result=0xFFFFFFFF80000000. DIVU src2=0 -> out_result=0xFFFFFFFFFFFFFFFF. REM src2=0, src1=5 -> out_result=5.
- Flush in WAIT, div_out_valid 10 cycles later -> DRAIN, in_ready=0 until the pulse, then IDLE; out_valid never asserts.
- DONE with out_ready=0 for 5 cycles -> out_result stable and in_ready=0; out_ready=1 -> IDLE the next cycle; flush & out_ready together -> no transfer.
- Cache enabled: DIV a,b then REM a,b -> the second op produces no div_valid, and out_valid comes one cycle after accept. Without the macro -> the second op issues to the divider.
